// File: rtl/dec_sched_pkg.sv
// Shared definitions for the round-robin chip-select scheduler.
package dec_sched_pkg;
  localparam int NREQ = 8;
  localparam int SELW = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GUARD  = 2'd2
  } state_t;
endpackage

// File: rtl/dec3to8_n.sv
// Combinational 3-to-8 decoder with enable and active-low outputs.
module dec3to8_n
  import dec_sched_pkg::*;
(
  input  logic [SELW-1:0] sel,
  input  logic            en,
  output logic [NREQ-1:0] cs_n
);
  // NOTE: assign a default before any conditional write so no latch is inferred.
  always_comb begin
    cs_n = '1;
    if (en) cs_n[sel] = 1'b0;
  end
endmodule

// File: rtl/dec_cs_scheduler.sv
// Round-robin scheduler granting one requester at a time onto a shared
// active-low decoded select, with a hold window and a break-before-make gap.
module dec_cs_scheduler
  import dec_sched_pkg::*;
#(
  parameter int HOLD_CYCLES  = 4,
  parameter int GUARD_CYCLES = 1,
  parameter int CNT_W        = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  output logic [SELW-1:0]       sel,
  output logic                  en,
  output logic [NREQ-1:0]       cs_n,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy
);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [SELW-1:0]   ptr, ptr_n;
  logic [SELW-1:0]   sel_n;
  logic              en_n;
  logic              busy_n;
  logic [NREQ-1:0]   cs_n_n;

  // First set request scanning ptr+1, ptr+2, ... with wrap; the pointer itself ranks last.
  function automatic logic [SELW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [SELW-1:0] p);
    logic [SELW-1:0] k;
    rr_pick = p;
    for (int i = NREQ; i >= 1; i--) begin
      k = p + SELW'(i);
      if (r[k]) rr_pick = k;
    end
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    sel_n   = sel;
    en_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          sel_n   = rr_pick(req, ptr);
          en_n    = 1'b1;
          state_n = ACTIVE;
          cnt_n   = HOLD_LOAD;
        end
      end
      ACTIVE: begin
        if (!req[sel] || cnt == '0) begin
          ptr_n   = sel;
          state_n = GUARD;
          cnt_n   = GUARD_LOAD;
        end else begin
          en_n  = 1'b1;
          cnt_n = cnt - 1'b1;
        end
      end
      GUARD: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (|req) begin
          // ptr already points at the grant that just ended.
          sel_n   = rr_pick(req, ptr);
          en_n    = 1'b1;
          state_n = ACTIVE;
          cnt_n   = HOLD_LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // Decode the next-state select so cs_n/gnt come straight out of flops.
  dec3to8_n u_dec (
    .sel  (sel_n),
    .en   (en_n),
    .cs_n (cs_n_n)
  );

  // NOTE: sequential state uses non-blocking assignments to avoid simulation races.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= SELW'(NREQ - 1);
      sel   <= '0;
      en    <= 1'b0;
      cs_n  <= '1;
      gnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
      sel   <= sel_n;
      en    <= en_n;
      cs_n  <= cs_n_n;
      gnt   <= ~cs_n_n;
      busy  <= busy_n;
    end
  end
endmodule

// File: tb/tb_dec_cs_scheduler.sv
// Directed bench for dec_cs_scheduler: reset, hold window, round robin,
// early release, mid-grant reset and two-requester alternation.
module tb_dec_cs_scheduler;
  logic       clock;
  logic       reset;
  logic [7:0] req;
  logic [2:0] sel;
  logic       en;
  logic [7:0] cs_n;
  logic [7:0] gnt;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  dec_cs_scheduler #(
    .HOLD_CYCLES  (4),
    .GUARD_CYCLES (1),
    .CNT_W        (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .sel   (sel),
    .en    (en),
    .cs_n  (cs_n),
    .gnt   (gnt),
    .busy  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output invariants checked every cycle once reset has taken effect.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0(gnt) || cs_n !== ~gnt || en !== |gnt) begin
        errors++;
        $display("FAIL invariant t=%0t: gnt=%h cs_n=%h en=%b", $time, gnt, cs_n, en);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] r);
    reset = 1'b1;
    req   = r;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      step();
      mon_en = 1'b1;
      checks++;
      if ({sel, en, cs_n, gnt, busy} !== {3'd0, 1'b0, 8'hFF, 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL reset cyc%0d: sel=%0d en=%b cs_n=%h gnt=%h busy=%b want 0 0 ff 00 0",
                 c, sel, en, cs_n, gnt, busy);
      end
    end
  endtask

  // Continues straight out of test_reset with req=FF: grants 0..7 then 0 again.
  task automatic test_round_robin();
    logic [7:0] exp;
    logic [2:0] idx;
    reset = 1'b0;
    for (int g = 0; g < 9; g++) begin
      idx = 3'(g % 8);
      exp = ~(8'h01 << idx);
      for (int c = 0; c < 4; c++) begin
        step();
        checks++;
        if (cs_n !== exp || sel !== idx || busy !== 1'b1) begin
          errors++;
          $display("FAIL rr grant%0d cyc%0d: cs_n=%h sel=%0d busy=%b want %h %0d 1",
                   g, c, cs_n, sel, busy, exp, idx);
        end
      end
      step();
      checks++;
      if (cs_n !== 8'hFF || en !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL rr guard%0d: cs_n=%h en=%b busy=%b want ff 0 1", g, cs_n, en, busy);
      end
    end
  endtask

  task automatic test_hold();
    do_reset(8'h08);
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        checks++;
        if (cs_n !== 8'hF7 || sel !== 3'd3) begin
          errors++;
          $display("FAIL hold p%0d cyc%0d: cs_n=%h sel=%0d want f7 3", p, c, cs_n, sel);
        end
      end
      step();
      checks++;
      if (cs_n !== 8'hFF || sel !== 3'd3) begin
        errors++;
        $display("FAIL hold gap%0d: cs_n=%h sel=%0d want ff 3", p, cs_n, sel);
      end
    end
    step();
    checks++;
    if (cs_n !== 8'hF7) begin
      errors++;
      $display("FAIL hold regrant: cs_n=%h want f7", cs_n);
    end
  endtask

  task automatic test_early_release();
    do_reset(8'h21);
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (cs_n !== 8'hFE) begin
        errors++;
        $display("FAIL early first%0d: cs_n=%h want fe", c, cs_n);
      end
    end
    step();
    checks++;
    if (cs_n !== 8'hFF) begin
      errors++;
      $display("FAIL early gap: cs_n=%h want ff", cs_n);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (cs_n !== 8'hDF || sel !== 3'd5) begin
        errors++;
        $display("FAIL early grant5 cyc%0d: cs_n=%h sel=%0d want df 5", c, cs_n, sel);
      end
    end
    req = 8'h01;
    step();
    checks++;
    if (cs_n !== 8'hFF || busy !== 1'b1) begin
      errors++;
      $display("FAIL early drop: cs_n=%h busy=%b want ff 1", cs_n, busy);
    end
    step();
    checks++;
    if (cs_n !== 8'hFE || sel !== 3'd0) begin
      errors++;
      $display("FAIL early next: cs_n=%h sel=%0d want fe 0", cs_n, sel);
    end
    req = 8'h00;
    step();
    checks++;
    if (cs_n !== 8'hFF || busy !== 1'b1) begin
      errors++;
      $display("FAIL early guard: cs_n=%h busy=%b want ff 1", cs_n, busy);
    end
    step();
    checks++;
    if (cs_n !== 8'hFF || busy !== 1'b0 || en !== 1'b0) begin
      errors++;
      $display("FAIL early idle: cs_n=%h busy=%b en=%b want ff 0 0", cs_n, busy, en);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    do_reset(8'hFF);
    for (int c = 0; c < 60 && !found; c++) begin
      step();
      if (cs_n === 8'hBF) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrst wait: cs_n=%h never reached bf", cs_n);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({sel, en, cs_n, gnt, busy} !== {3'd0, 1'b0, 8'hFF, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL midrst values: sel=%0d en=%b cs_n=%h gnt=%h busy=%b want 0 0 ff 00 0",
               sel, en, cs_n, gnt, busy);
    end
    reset = 1'b0;
    step();
    checks++;
    if (cs_n !== 8'hFE || sel !== 3'd0) begin
      errors++;
      $display("FAIL midrst regrant: cs_n=%h sel=%0d want fe 0", cs_n, sel);
    end
  endtask

  task automatic test_alternate();
    logic [2:0] order [4] = '{3'd2, 3'd6, 3'd2, 3'd6};
    logic [7:0] exp;
    do_reset(8'h44);
    for (int g = 0; g < 4; g++) begin
      exp = ~(8'h01 << order[g]);
      for (int c = 0; c < 4; c++) begin
        step();
        checks++;
        if (cs_n !== exp || $countones(~cs_n) > 1) begin
          errors++;
          $display("FAIL alt grant%0d cyc%0d: cs_n=%h want %h", g, c, cs_n, exp);
        end
      end
      step();
      checks++;
      if (cs_n !== 8'hFF) begin
        errors++;
        $display("FAIL alt gap%0d: cs_n=%h want ff", g, cs_n);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    test_reset();
    test_round_robin();
    test_hold();
    test_early_release();
    test_reset_mid();
    test_alternate();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
